acc_alu_ctrl: RTL and testbench
===============================

# acc_alu_ctrl

Parametrised accumulator ALU with integrated control FSM and valid/ready operand handshake. It holds a WIDTH-bit accumulator, applies one of eight opcode-selected operations per accepted transaction, and detects unsigned overflow with a selectable wrap/saturate policy. It is the next-generation datapath-plus-controller for the ALU subsystem: one registered accumulator replaces the separate input/accumulator flops and the one-hot output mux.

## Interface
- WIDTH, 8: accumulator and operand width, in bits; WIDTH >= 2.
- SATURATE, 0: selects the overflow policy. 0 wraps to the low WIDTH bits. 1 clamps the result.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  power enable; 0 forces OFF.
- in_valid  in  1  operand/op transaction request.
- in_ready  out  1  block can accept this cycle.
- op  in  3  opcode:
  - 000 LOAD
  - 001 AND
  - 010 OR
  - 011 XOR
  - 100 NOT
  - 101 ADD
  - 110 SUB
  - 111 MUL
- operand  in  WIDTH  second operand; ignored for NOT.
- acc  out  WIDTH  accumulator (registered).
- out_valid  out  1  one-cycle pulse: acc holds the result of the previous accepted op.
- err  out  1  high while the FSM is in ERROR.
- state  out  2  FSM state for debug/status.

## Operation
- Transfer: a transaction is accepted when in_valid & in_ready are both high at a rising edge.
- in_ready is combinational: in_ready = en & (state==READY | state==RUN).
- FSM states:
  - OFF=00: no acceptance. en=1 -> READY.
  - READY=01: only LOAD has effect. Acc<=operand, -> RUN. Any other accepted op is dropped: acc unchanged, no out_valid.
  - RUN=10: every accepted op updates acc. An overflowing op -> ERROR. No overflow -> stay RUN.
  - ERROR=11: lasts exactly one cycle, err=1, in_ready=0, then -> READY.
- en=0 in any state -> OFF on the next edge, acc held. en has priority over overflow and all other transitions.
- Arithmetic is unsigned, on acc (A) and operand (B):
  - LOAD: B.
  - AND, OR, XOR: bitwise.
  - NOT: ~A.
  - ADD: A+B. Overflow = carry out of bit WIDTH-1.
  - SUB: A-B. Overflow = borrow (B>A).
  - MUL: full 2*WIDTH-bit product. Overflow = any of the upper WIDTH bits nonzero.
- Overflow result:
  - SATURATE=0: low WIDTH bits of the exact result.
  - SATURATE=1: ADD/MUL -> all ones; SUB -> 0.
- On overflow, acc takes the wrapped or saturated value. The op still counts as completed and out_valid pulses.
- LOAD in RUN reloads acc and never overflows.

## Timing
- Reset values: acc=0, state=OFF, out_valid=0, err=0. in_ready=0 while reset is asserted.
- Reset is asynchronous: outputs clear immediately on assertion, including mid-transaction; the in-flight op is lost.
- Deassertion is sampled at the next clk edge.
- Latency: acc and out_valid update on the accepting edge, visible the following cycle.
- Throughput: one op per cycle in RUN.
- Overflow edge: acc updates, state->ERROR, out_valid=1 and err=1 in the same following cycle.
- The next cycle is READY (in_ready=1 if en). Earliest following LOAD acceptance: 2 cycles after the overflowing op.
- OFF->READY takes 1 cycle after en rises.
- en falling with in_valid high in RUN: in_ready drops combinationally, nothing is accepted, OFF next edge.

## Test plan
- Reset/power-up, WIDTH=8: rst low -> acc=0x00, state=00, in_ready=0. Release, en=1 -> state=01 next cycle, in_ready=1.
- Basic flow:
  - READY: ADD 0x05 -> dropped, acc=0x00, no out_valid.
  - LOAD 0x3C -> acc=0x3C, state=10.
  - ADD 0x05 -> acc=0x41, out_valid pulse.
  - AND 0x0F -> 0x01. NOT -> 0xFE. XOR 0xFF -> 0x01.
- ADD overflow: acc=0xF0, ADD 0x20.
  - SATURATE=0 -> acc=0x10.
  - SATURATE=1 -> acc=0xFF.
  - Either policy: err=1 for exactly 1 cycle, state 11 then 01, in_ready=0 during ERROR.
- SUB/MUL boundaries:
  - 0x03 SUB 0x05 -> 0xFE wrap / 0x00 sat, err.
  - 0x0F MUL 0x11 -> 0xFF, no err.
  - 0x10 MUL 0x10 -> 0x00 wrap / 0xFF sat, err.
  - 0x05 SUB 0x05 -> 0x00, no err.
- Back-to-back: 4 consecutive accepted ADD 0x01 from 0x00 -> acc 0x01..0x04 on successive cycles, out_valid high 4 cycles.
- Control interrupts and width:
  - en=0 in RUN with in_valid=1 -> no acceptance, state=00, acc held.
  - rst asserted mid-cycle -> immediate acc=0, state=00.
  - WIDTH=16: 0xFFFF ADD 0x0001 -> 0x0000, err.

Source files
------------

// File: rtl/acc_alu_ctrl.sv
// -----------------------------------------------------------------------------
// acc_alu_ctrl
//
// Accumulator ALU with an integrated OFF/READY/RUN/ERROR controller and a
// valid/ready operand handshake. Each accepted transaction applies one of
// eight opcodes to the registered accumulator. Unsigned overflow on ADD, SUB
// or MUL either wraps to the low WIDTH bits or clamps, depending on SATURATE.
// An overflow sends the controller through a single ERROR cycle back to
// READY, where only a LOAD restarts accumulation.
//
// Parameters
//   WIDTH     accumulator / operand width in bits (>= 2)
//   SATURATE  0: wrap on overflow, 1: clamp (ADD/MUL -> all ones, SUB -> 0)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active low
//   en         in   power enable; low forces OFF on the next edge
//   in_valid   in   transaction request
//   in_ready   out  block can accept this cycle (combinational)
//   op         in   opcode: LOAD AND OR XOR NOT ADD SUB MUL (000..111)
//   operand    in   second operand B (ignored by NOT)
//   acc        out  registered accumulator
//   out_valid  out  one-cycle pulse: acc holds the result of the last op
//   err        out  high while the controller is in ERROR
//   state      out  controller state: 00 OFF, 01 READY, 10 RUN, 11 ERROR
// -----------------------------------------------------------------------------
module acc_alu_ctrl #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc,
  output logic             out_valid,
  output logic             err,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_READY = 2'b01,
    S_RUN   = 2'b10,
    S_ERROR = 2'b11
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  // Returns {overflow, low WIDTH bits of the exact result}.
  function automatic logic [WIDTH:0] alu_exact(
    input logic [2:0]       o,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res;
    logic               ovf;
    sum  = {1'b0, a} + {1'b0, b};
    // The extra top bit of the difference is the borrow, i.e. B > A.
    diff = {1'b0, a} - {1'b0, b};
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    res  = b;
    ovf  = 1'b0;
    case (o)
      OP_LOAD: res = b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        ovf = sum[WIDTH];
      end
      OP_SUB: begin
        res = diff[WIDTH-1:0];
        ovf = diff[WIDTH];
      end
      OP_MUL: begin
        res = prod[WIDTH-1:0];
        ovf = |prod[2*WIDTH-1:WIDTH];
      end
      default: res = b;
    endcase
    return {ovf, res};
  endfunction

  // Applies the overflow policy to an already wrapped result.
  function automatic logic [WIDTH-1:0] sat_result(
    input logic [2:0]       o,
    input logic [WIDTH-1:0] wrapped,
    input logic             ovf
  );
    if (SATURATE && ovf) begin
      return (o == OP_SUB) ? '0 : '1;
    end
    return wrapped;
  endfunction

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] acc_p1;
  logic             vld_p1;

  logic             accept_p0;
  logic             upd_p0;
  logic [WIDTH:0]   alu_p0;
  logic             ovf_p0;
  logic [WIDTH-1:0] res_p0;

  // ---- stage p0: handshake, operation and next-state decode ----
  always_comb begin
    in_ready  = en & ((state_q == S_READY) | (state_q == S_RUN));
    accept_p0 = in_valid & in_ready;
    // In READY only LOAD takes effect; other accepted ops are dropped.
    upd_p0    = accept_p0 & ((state_q == S_RUN) | (op == OP_LOAD));
    alu_p0    = alu_exact(op, acc_p1, operand);
    ovf_p0    = alu_p0[WIDTH];
    res_p0    = sat_result(op, alu_p0[WIDTH-1:0], ovf_p0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:   state_d = S_READY;
      S_READY: if (accept_p0 && (op == OP_LOAD)) state_d = S_RUN;
      S_RUN:   if (accept_p0 && ovf_p0) state_d = S_ERROR;
      S_ERROR: state_d = S_READY;
      default: state_d = S_OFF;
    endcase
    // Dropping enable overrides every other transition, including overflow.
    if (!en) begin
      state_d = S_OFF;
    end
  end

  // ---- stage p1: registered controller state, accumulator and valid ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= upd_p0;
      if (upd_p0) begin
        acc_p1 <= res_p0;
      end
    end
  end

  assign acc       = acc_p1;
  assign out_valid = vld_p1;
  assign err       = (state_q == S_ERROR);
  assign state     = state_q;

endmodule

// File: tb/tb_acc_alu_ctrl.sv
module tb_acc_alu_ctrl;

  localparam logic [2:0] LOAD = 3'd0;
  localparam logic [2:0] AND_ = 3'd1;
  localparam logic [2:0] NOT_ = 3'd4;
  localparam logic [2:0] XOR_ = 3'd3;
  localparam logic [2:0] ADD  = 3'd5;
  localparam logic [2:0] SUB  = 3'd6;
  localparam logic [2:0] MUL  = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [7:0]  b8 = 8'd0;
  logic [15:0] b16 = 16'd0;

  logic        rdy_w, vld_w, err_w;
  logic [7:0]  acc_w;
  logic [1:0]  st_w;
  logic        rdy_s, vld_s, err_s;
  logic [7:0]  acc_s;
  logic [1:0]  st_s;
  logic        rdy_x, vld_x, err_x;
  logic [15:0] acc_x;
  logic [1:0]  st_x;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  acc_alu_ctrl #(.WIDTH(8), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy_w),
    .op(op), .operand(b8), .acc(acc_w), .out_valid(vld_w), .err(err_w), .state(st_w));

  acc_alu_ctrl #(.WIDTH(8), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy_s),
    .op(op), .operand(b8), .acc(acc_s), .out_valid(vld_s), .err(err_s), .state(st_s));

  acc_alu_ctrl #(.WIDTH(16), .SATURATE(1'b0)) dut_x (
    .clk(clk), .rst(rst_n), .en(en), .in_valid(in_valid), .in_ready(rdy_x),
    .op(op), .operand(b16), .acc(acc_x), .out_valid(vld_x), .err(err_x), .state(st_x));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: state numbers 0 OFF, 1 READY, 2 RUN, 3 ERROR; arithmetic done
  // on wide integers and reduced to w bits afterwards.
  function automatic void mstep(input int w, input bit sat, input bit e, input bit v,
                                input int o, input longint b,
                                inout int st, inout longint a, output bit vld);
    longint m;
    longint r;
    bit     ovf;
    m   = (longint'(1) << w) - 1;
    vld = 1'b0;
    ovf = 1'b0;
    r   = a;
    if (!e) begin
      st = 0;
      return;
    end
    if (st == 0 || st == 3) begin
      st = 1;
    end else if (st == 1) begin
      if (v && o == 0) begin
        a = b; st = 2; vld = 1'b1;
      end
    end else if (v) begin
      case (o)
        0: r = b;
        1: r = a & b;
        2: r = a | b;
        3: r = a ^ b;
        4: r = (~a) & m;
        5: begin r = a + b; ovf = (r > m); end
        6: begin ovf = (b > a); r = a - b; end
        default: begin r = a * b; ovf = (r > m); end
      endcase
      if (ovf && sat) r = (o == 6) ? 0 : m;
      a   = r & m;
      vld = 1'b1;
      st  = ovf ? 3 : 2;
    end
  endfunction

  int     ms[3];
  longint ma[3];
  bit     mv[3];

  initial begin
    for (int i = 0; i < 3; i++) begin ms[i] = 0; ma[i] = 0; mv[i] = 1'b0; end
  end

  always @(posedge clk or negedge rst_n) begin : model
    int     s;
    longint a;
    bit     v;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin ms[i] <= 0; ma[i] <= 0; mv[i] <= 1'b0; end
    end else begin
      for (int i = 0; i < 3; i++) begin
        s = ms[i];
        a = ma[i];
        mstep((i == 2) ? 16 : 8, (i == 1), en, in_valid, int'(op),
              (i == 2) ? longint'(b16) : longint'(b8), s, a, v);
        ms[i] <= s;
        ma[i] <= a;
        mv[i] <= v;
      end
    end
  end

  function automatic logic exp_rdy(input int s);
    return en && (s == 1 || s == 2);
  endfunction

  always @(negedge clk) begin
    chk("w8_acc",   64'(acc_w), 64'(ma[0]));
    chk("w8_state", 64'(st_w),  64'(ms[0]));
    chk("w8_vld",   64'(vld_w), 64'(mv[0]));
    chk("w8_err",   64'(err_w), 64'(ms[0] == 3));
    chk("w8_rdy",   64'(rdy_w), 64'(exp_rdy(ms[0])));
    chk("s8_acc",   64'(acc_s), 64'(ma[1]));
    chk("s8_state", 64'(st_s),  64'(ms[1]));
    chk("s8_vld",   64'(vld_s), 64'(mv[1]));
    chk("s8_err",   64'(err_s), 64'(ms[1] == 3));
    chk("s8_rdy",   64'(rdy_s), 64'(exp_rdy(ms[1])));
    chk("w16_acc",  64'(acc_x), 64'(ma[2]));
    chk("w16_state",64'(st_x),  64'(ms[2]));
    chk("w16_vld",  64'(vld_x), 64'(mv[2]));
    chk("w16_err",  64'(err_x), 64'(ms[2] == 3));
    chk("w16_rdy",  64'(rdy_x), 64'(exp_rdy(ms[2])));
  end

  // Called at posedge+1; applies inputs for the coming edge, returns at the
  // next posedge+1 with that edge's results visible.
  task automatic cyc(input bit e, input bit v, input logic [2:0] o,
                     input logic [7:0] x8, input logic [15:0] x16);
    en = e; in_valid = v; op = o; b8 = x8; b16 = x16;
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  edges8  [4] = '{8'h00, 8'h01, 8'hFF, 8'h80};
  logic [15:0] edges16 [4] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000};
  logic [31:0] r32;
  logic [7:0]  x8;
  logic [15:0] x16;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_acc", 64'(acc_w), 64'h00);
    chk("rst_state", 64'(st_w), 64'h0);
    chk("rst_rdy", 64'(rdy_w), 64'h0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, LOAD, 8'h00, 16'h0000);
    chk("off_hold", 64'(st_w), 64'h0);
    cyc(1'b1, 1'b0, LOAD, 8'h00, 16'h0000);
    chk("pwr_ready", 64'(st_w), 64'h1);
    chk("pwr_rdy", 64'(rdy_w), 64'h1);

    cyc(1'b1, 1'b1, ADD, 8'h05, 16'h0005);
    chk("drop_acc", 64'(acc_w), 64'h00);
    chk("drop_vld", 64'(vld_w), 64'h0);
    cyc(1'b1, 1'b1, LOAD, 8'h3C, 16'h003C);
    chk("load_acc", 64'(acc_w), 64'h3C);
    chk("load_state", 64'(st_w), 64'h2);
    cyc(1'b1, 1'b1, ADD, 8'h05, 16'h0005);
    chk("add_acc", 64'(acc_w), 64'h41);
    chk("add_vld", 64'(vld_w), 64'h1);
    cyc(1'b1, 1'b1, AND_, 8'h0F, 16'h000F);
    chk("and_acc", 64'(acc_w), 64'h01);
    cyc(1'b1, 1'b1, NOT_, 8'h00, 16'h0000);
    chk("not_acc", 64'(acc_w), 64'hFE);
    cyc(1'b1, 1'b1, XOR_, 8'hFF, 16'h00FF);
    chk("xor_acc", 64'(acc_w), 64'h01);

    cyc(1'b1, 1'b1, LOAD, 8'hF0, 16'h00F0);
    cyc(1'b1, 1'b1, ADD, 8'h20, 16'h0020);
    chk("addovf_wrap", 64'(acc_w), 64'h10);
    chk("addovf_sat", 64'(acc_s), 64'hFF);
    chk("addovf_state", 64'(st_w), 64'h3);
    chk("addovf_err", 64'(err_s), 64'h1);
    chk("addovf_rdy", 64'(rdy_w), 64'h0);
    cyc(1'b1, 1'b0, LOAD, 8'h00, 16'h0000);
    chk("post_err_state", 64'(st_w), 64'h1);
    chk("post_err_err", 64'(err_w), 64'h0);
    chk("post_err_rdy", 64'(rdy_w), 64'h1);

    cyc(1'b1, 1'b1, LOAD, 8'h03, 16'h0003);
    cyc(1'b1, 1'b1, SUB, 8'h05, 16'h0005);
    chk("subovf_wrap", 64'(acc_w), 64'hFE);
    chk("subovf_sat", 64'(acc_s), 64'h00);
    chk("subovf_err", 64'(err_w), 64'h1);
    cyc(1'b1, 1'b0, LOAD, 8'h00, 16'h0000);
    cyc(1'b1, 1'b1, LOAD, 8'h0F, 16'h000F);
    cyc(1'b1, 1'b1, MUL, 8'h11, 16'h0011);
    chk("mul_ok_acc", 64'(acc_s), 64'hFF);
    chk("mul_ok_err", 64'(err_w), 64'h0);
    cyc(1'b1, 1'b1, LOAD, 8'h10, 16'h0010);
    cyc(1'b1, 1'b1, MUL, 8'h10, 16'h0010);
    chk("mulovf_wrap", 64'(acc_w), 64'h00);
    chk("mulovf_sat", 64'(acc_s), 64'hFF);
    chk("mulovf_err", 64'(err_w), 64'h1);
    cyc(1'b1, 1'b0, LOAD, 8'h00, 16'h0000);
    cyc(1'b1, 1'b1, LOAD, 8'h05, 16'h0005);
    cyc(1'b1, 1'b1, SUB, 8'h05, 16'h0005);
    chk("sub_eq_acc", 64'(acc_w), 64'h00);
    chk("sub_eq_err", 64'(err_w), 64'h0);

    cyc(1'b1, 1'b1, LOAD, 8'h00, 16'h0000);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, 1'b1, ADD, 8'h01, 16'h0001);
      chk("b2b_acc", 64'(acc_w), 64'(k));
      chk("b2b_vld", 64'(vld_w), 64'h1);
    end

    en = 1'b0; in_valid = 1'b1; op = ADD; b8 = 8'h01; b16 = 16'h0001;
    #1;
    chk("en_low_rdy", 64'(rdy_w), 64'h0);
    @(posedge clk);
    #1;
    chk("en_low_state", 64'(st_w), 64'h0);
    chk("en_low_acc", 64'(acc_w), 64'h04);

    cyc(1'b1, 1'b0, LOAD, 8'h00, 16'h0000);
    cyc(1'b1, 1'b1, LOAD, 8'h77, 16'h0077);
    en = 1'b1; in_valid = 1'b1; op = ADD; b8 = 8'h01; b16 = 16'h0001;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_acc", 64'(acc_w), 64'h00);
    chk("async_rst_state", 64'(st_w), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    cyc(1'b1, 1'b0, LOAD, 8'h00, 16'h0000);
    cyc(1'b1, 1'b1, LOAD, 8'h00, 16'hFFFF);
    cyc(1'b1, 1'b1, ADD, 8'h01, 16'h0001);
    chk("w16_ovf_acc", 64'(acc_x), 64'h0000);
    chk("w16_ovf_err", 64'(err_x), 64'h1);
    cyc(1'b1, 1'b0, LOAD, 8'h00, 16'h0000);

    for (int n = 0; n < 3000; n++) begin
      r32 = $urandom;
      x8  = ($urandom_range(0, 3) == 0) ? edges8[$urandom_range(0, 3)] : r32[7:0];
      x16 = ($urandom_range(0, 3) == 0) ? edges16[$urandom_range(0, 3)] : r32[23:8];
      cyc($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0,
          3'($urandom_range(0, 7)), x8, x16);
      if ($urandom_range(0, 399) == 0) begin
        #2;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
      end
    end

    cyc(1'b0, 1'b0, LOAD, 8'h00, 16'h0000);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
